// File: rtl/ctrl_pkg.sv
// Shared types, opcode/ALUOp encodings and opcode classification for the
// multicycle control unit.
package ctrl_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_IMM,
    C_BRANCH,
    C_LOAD,
    C_STORE,
    C_HALT,
    C_NOP
  } op_class_e;

  localparam logic [OP_W-1:0] OP_STORE = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0100;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'b1000;
  localparam logic [OP_W-1:0] OP_BRZ   = 4'b1001;
  localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SHL  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SHR  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_PASS = 3'b111;

  typedef struct packed {
    op_class_e              cls;
    logic [ALU_W-1:0]       aluop;
  } op_dec_t;

  // Class plus the ALUOp the instruction drives in EXEC.
  function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
    op_dec_t d;
    d.cls   = C_NOP;
    d.aluop = ALU_PASS;
    case (op)
      OP_ADD:   begin d.cls = C_ALU;    d.aluop = ALU_ADD; end
      OP_SUB:   begin d.cls = C_ALU;    d.aluop = ALU_SUB; end
      OP_AND:   begin d.cls = C_ALU;    d.aluop = ALU_AND; end
      OP_XOR:   begin d.cls = C_ALU;    d.aluop = ALU_XOR; end
      OP_SHL:   begin d.cls = C_ALU;    d.aluop = ALU_SHL; end
      OP_SHR:   begin d.cls = C_ALU;    d.aluop = ALU_SHR; end
      OP_ADDI:  begin d.cls = C_IMM;    d.aluop = ALU_ADD; end
      OP_BRZ:   begin d.cls = C_BRANCH; d.aluop = ALU_SUB; end
      OP_LOAD:  begin d.cls = C_LOAD;   d.aluop = ALU_ADD; end
      OP_STORE: begin d.cls = C_STORE;  d.aluop = ALU_ADD; end
      OP_HALT:  begin d.cls = C_HALT;   d.aluop = ALU_PASS; end
      default:  begin d.cls = C_NOP;    d.aluop = ALU_PASS; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: registered opcode -> class and ALUOp.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output op_dec_t         dec_c
);

  assign dec_c = decode_op(opcode);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM sequencing, memory wait
// states, halt/start handling and a retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned OPWIDTH   = 3,
  parameter int unsigned MCODEBITS = 9,
  parameter int unsigned OPBITS    = 4,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 zero,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 done,
  output logic [CNTW-1:0]      instr_cnt
);

  state_e              state_q, state_d;
  logic [OPBITS-1:0]   op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNTW-1:0]     instr_cnt_q, instr_cnt_d;
  op_dec_t             dec_c;
  logic                unused_instr_c;

  // Only the opcode field of the instruction matters to the controller.
  assign unused_instr_c = ^instr[MCODEBITS-OPBITS-1:0];

  ctrl_decode u_decode (
    .opcode (OP_W'(op_q)),
    .dec_c  (dec_c)
  );

  // Next state plus Moore outputs; Branch alone follows the live zero flag.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = wait_q;
    ir_load     = 1'b0;
    pc_en       = 1'b0;
    RegDst      = 1'b0;
    Branch      = 1'b0;
    MemtoReg    = 1'b0;
    MemWrite    = 1'b0;
    ALUSrc      = 1'b0;
    RegWrite    = 1'b0;
    ALUOp       = {OPWIDTH{1'b1}};
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_load = 1'b1;
        op_d    = instr[MCODEBITS-1 -: OPBITS];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (dec_c.cls == C_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        ALUOp   = OPWIDTH'(dec_c.aluop);
        state_d = S_FETCH;
        case (dec_c.cls)
          C_ALU: begin
            RegWrite = 1'b1;
            pc_en    = 1'b1;
          end
          C_IMM: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
            pc_en    = 1'b1;
          end
          C_BRANCH: begin
            Branch = zero;
            pc_en  = 1'b1;
          end
          C_LOAD, C_STORE: begin
            ALUSrc  = 1'b1;
            wait_d  = WAIT_W'(MEM_LAT);
            state_d = S_MEM;
          end
          default: begin
            pc_en = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        MemWrite = (dec_c.cls == C_STORE);
        MemtoReg = (dec_c.cls == C_LOAD);
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          RegWrite = (dec_c.cls == C_LOAD);
          pc_en    = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_HALT: begin
        done = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    instr_cnt_d = instr_cnt_q + CNTW'(pc_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      wait_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MEM_LAT=2/CNTW=16 and
// MEM_LAT=0/CNTW=4) checked every cycle against an instruction-level model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic       reg_dst;
    logic       branch;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [2:0] aluop;
    logic       done;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] instr;
  logic       zero;

  logic       ir_load0, pc_en0, reg_dst0, branch0, mtr0, mw0, src0, rw0, done0;
  logic [2:0] alu0;
  logic [15:0] cnt0;
  logic       ir_load1, pc_en1, reg_dst1, branch1, mtr1, mw1, src1, rw1, done1;
  logic [2:0] alu1;
  logic [3:0] cnt1;

  multicycle_ctrl #(
    .OPWIDTH(3), .MCODEBITS(9), .OPBITS(4), .MEM_LAT(2), .CNTW(16)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .zero(zero),
    .ir_load(ir_load0), .pc_en(pc_en0), .RegDst(reg_dst0), .Branch(branch0),
    .MemtoReg(mtr0), .MemWrite(mw0), .ALUSrc(src0), .RegWrite(rw0),
    .ALUOp(alu0), .done(done0), .instr_cnt(cnt0)
  );

  multicycle_ctrl #(
    .OPWIDTH(3), .MCODEBITS(9), .OPBITS(4), .MEM_LAT(0), .CNTW(4)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .zero(zero),
    .ir_load(ir_load1), .pc_en(pc_en1), .RegDst(reg_dst1), .Branch(branch1),
    .MemtoReg(mtr1), .MemWrite(mw1), .ALUSrc(src1), .RegWrite(rw1),
    .ALUOp(alu1), .done(done1), .instr_cnt(cnt1)
  );

  obs_t        obs [2];
  logic [31:0] cnt_obs [2];
  assign obs[0] = {ir_load0, pc_en0, reg_dst0, branch0, mtr0, mw0, src0, rw0, alu0, done0};
  assign obs[1] = {ir_load1, pc_en1, reg_dst1, branch1, mtr1, mw1, src1, rw1, alu1, done1};
  assign cnt_obs[0] = {16'd0, cnt0};
  assign cnt_obs[1] = {28'd0, cnt1};

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: per-DUT queue of expected output cycles.
  obs_t        rb [2][32];
  int          hd [2];
  int          tl [2];
  bit          halted [2];
  int unsigned mcnt [2];
  obs_t        ce;

  function automatic obs_t mk(input logic irl, input logic pc, input logic brz,
                              input logic mtr, input logic mw, input logic src,
                              input logic rw, input logic [2:0] alu);
    obs_t e;
    e = '0;
    e.ir_load = irl; e.pc_en = pc; e.branch = brz; e.memtoreg = mtr;
    e.memwrite = mw; e.alusrc = src; e.regwrite = rw; e.aluop = alu;
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'h1: return 3'b000;
      4'h3: return 3'b001;
      4'h4: return 3'b010;
      4'h5: return 3'b011;
      4'h6: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  task automatic push(input int d, input obs_t e);
    rb[d][tl[d] % 32] = e;
    tl[d]++;
  endtask

  task automatic expand(input int d, input logic [3:0] op);
    int lat;
    lat = (d == 0) ? 2 : 0;
    push(d, mk(0, 0, 0, 0, 0, 0, 0, 3'b111));
    case (op)
      4'hF: halted[d] = 1'b1;
      4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: push(d, mk(0, 1, 0, 0, 0, 0, 1, alu_of(op)));
      4'h8: push(d, mk(0, 1, 0, 0, 0, 1, 1, 3'b000));
      4'h9: push(d, mk(0, 1, 1, 0, 0, 0, 0, 3'b001));
      4'h0, 4'h2: begin
        push(d, mk(0, 0, 0, 0, 0, 1, 0, 3'b000));
        for (int k = 0; k <= lat; k++)
          push(d, mk(0, k == lat, 0, op == 4'h2, op == 4'h0, 0, (k == lat) && (op == 4'h2), 3'b111));
      end
      default: push(d, mk(0, 1, 0, 0, 0, 0, 0, 3'b111));
    endcase
  endtask

  task automatic advance(input int d);
    obs_t e;
    int unsigned modv;
    modv = (d == 0) ? 32'd65536 : 32'd16;
    if (hd[d] != tl[d]) begin
      e = rb[d][hd[d] % 32];
      hd[d]++;
      if (e.pc_en) mcnt[d] = (mcnt[d] + 1) % modv;
      if (e.ir_load) expand(d, instr[8:5]);
      if (hd[d] == tl[d] && !halted[d]) push(d, mk(1, 0, 0, 0, 0, 0, 0, 3'b111));
    end else if (start) begin
      halted[d] = 1'b0;
      push(d, mk(1, 0, 0, 0, 0, 0, 0, 3'b111));
    end
  endtask

  // Compare both DUTs against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        hd[d] = 0; tl[d] = 0; halted[d] = 1'b0; mcnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (hd[d] != tl[d]) begin
          ce = rb[d][hd[d] % 32];
        end else begin
          ce = mk(0, 0, 0, 0, 0, 0, 0, 3'b111);
          ce.done = halted[d];
        end
        ce.branch = ce.branch & zero;
        chk($sformatf("dut%0d_outputs", d), 32'(obs[d]), 32'(ce));
        chk($sformatf("dut%0d_instr_cnt", d), cnt_obs[d], mcnt[d]);
        advance(d);
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = '0; zero = 1'b0;
    #2;
    chk("rst_aluop", alu0, 3'b111);
    chk("rst_cnt", cnt0, 0);
    chk("rst_done_irload", {done0, ir_load0}, 2'b00);
    step(2);
    rst_n = 1'b1;

    start = 1'b1; instr = 9'b0001_10101;
    step(1);
    chk("add_ir_load", ir_load0, 1'b1);
    start = 1'b0;
    step(2);
    chk("add_aluop", alu0, 3'b000);
    chk("add_regwrite_pc_en", {rw0, pc_en0}, 2'b11);
    step(1);
    chk("add_cnt", cnt0, 1);
    instr = 9'b0010_00011;
    step(3);
    chk("load_mem_first", {mtr0, rw0, pc_en0}, 3'b100);
    step(2);
    chk("load_mem_last", {mtr0, rw0, pc_en0}, 3'b111);
    step(1);
    chk("load_cnt", cnt0, 2);
    chk("load_next_fetch", ir_load0, 1'b1);
    instr = 9'b1001_00000; zero = 1'b0;
    step(2);
    chk("brz_zero0", {branch0, pc_en0, alu0}, 5'b0_1_001);
    step(1);
    zero = 1'b1;
    step(2);
    chk("brz_zero1", {branch0, pc_en0, alu0}, 5'b1_1_001);
    step(1);
    chk("brz_cnt", cnt0, 4);
    instr = 9'b1111_00000;
    step(2);
    for (int i = 0; i < 10; i++) begin
      chk("halt_done_hold", {done0, pc_en0}, 2'b10);
      step(1);
    end
    chk("halt_cnt", cnt0, 4);
    start = 1'b1; instr = 9'b0000_01010;
    step(1);
    chk("halt_resume", {ir_load0, done0}, 2'b10);
    start = 1'b0;
    step(3);
    chk("store_memwrite", mw0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_memwrite", mw0, 1'b0);
    chk("rst_async_cnt", cnt0, 0);
    chk("rst_async_aluop", alu0, 3'b111);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("post_rst_quiet", {ir_load0, pc_en0, mw0, rw0}, 4'b0000);
    end

    start = 1'b1; instr = 9'b1010_00000; zero = 1'b0;
    step(1);
    start = 1'b0;
    step(45);
    chk("wrap_cnt15", cnt1, 4'd15);
    step(3);
    chk("wrap_cnt0", cnt1, 4'd0);
    chk("nop_cnt16_wide", cnt0, 16);

    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      instr = 9'($urandom);
      zero  = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised, sequential control unit that replaces the single-cycle combinational decoder in the processor datapath. It registers the instruction opcode and steps each instruction through FETCH/DECODE/EXEC/MEM phases. It stalls a configurable number of cycles for data-memory access and handles halt and start. It also keeps a retired-instruction counter. It sits between instruction memory and the datapath (register file, ALU, data memory, PC).

## Interface
Parameters:
- OPWIDTH, 3, ALUOp width
- MCODEBITS, 9, instruction width
- OPBITS, 4, opcode field width; opcode = instr[MCODEBITS-1 -: OPBITS]
- MEM_LAT, 2, extra data-memory wait cycles (0..15)
- CNTW, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin/resume execution (level sampled in IDLE/HALT)
- instr  in  MCODEBITS  instruction word, valid during FETCH
- zero  in  1  ALU zero flag
- ir_load  out  1  instruction register load strobe
- pc_en  out  1  PC update strobe (one per retired instruction)
- RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  datapath controls
- ALUOp  out  OPWIDTH  ALU operation
- done  out  1  high while halted
- instr_cnt  out  CNTW  retired-instruction count

## Operation
- Opcode map: STORE 0000, ADD 0001, LOAD 0010, SUB 0011, AND 0100, XOR 0101, SHL 0110, SHR 0111, ADDI 1000, BRZ 1001, HALT 1111. All others are NOP.
- ALUOp codes: ADD 000, SUB 001, AND 010, XOR 011, SHL 100, SHR 101, PASS 111 (default).
- Output defaults in every state: all 1-bit outputs 0, ALUOp = 111. RegDst is always 0.
- IDLE: start=1 -> FETCH.
- FETCH: ir_load=1; opcode register captures instr at the edge; -> DECODE.
- DECODE: no strobes. HALT opcode -> HALT; else -> EXEC.
- EXEC, by opcode class:
  - ALU ops: mapped ALUOp, RegWrite=1, pc_en=1; -> FETCH.
  - ADDI: ALUOp=000, ALUSrc=1, RegWrite=1, pc_en=1; -> FETCH.
  - BRZ: ALUOp=001, Branch=zero (combinational), pc_en=1; -> FETCH.
  - NOP: pc_en=1 only; -> FETCH.
  - LOAD/STORE: ALUOp=000, ALUSrc=1; wait counter loaded with MEM_LAT; -> MEM.
- MEM:
  - STORE: MemWrite=1 held every MEM cycle.
  - LOAD: MemtoReg=1 held.
  - Counter decrements each cycle while nonzero.
  - In the cycle with counter==0: LOAD also RegWrite=1; both pc_en=1; -> FETCH.
  - MEM_LAT=0 gives exactly one MEM cycle.
- HALT: done=1. start=1 -> FETCH. PC is not reset.
- instr_cnt increments on every cycle with pc_en=1 and wraps 2^CNTW-1 -> 0. HALT does not count.

## Timing
- Reset (asynchronous, immediate): state=IDLE, opcode reg=0, wait counter=0, instr_cnt=0. All outputs take their defaults (ALUOp=111, others 0), including mid-instruction; no partial write strobe survives reset.
- Outputs are Moore-decoded from state + registered opcode. The only exception is Branch, which also depends on the current zero.
- CPI: ALU/ADDI/BRZ/NOP = 3 (FETCH, DECODE, EXEC); LOAD/STORE = 4 + MEM_LAT; HALT = 2 to reach HALT.
- start is ignored outside IDLE/HALT.
- instr changes outside FETCH have no effect.
- RegWrite and pc_en are single-cycle pulses per instruction. MemWrite lasts MEM_LAT+1 cycles.

## Structure
- Package ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, HALT)
  - opcode localparams
  - ALUOp localparams
  - an opcode-class function (alu/imm/branch/load/store/halt/nop) returning the ALUOp mapping
- One sub-module, ctrl_decode: combinational opcode -> class + ALUOp, used by the FSM.
- FSM, wait counter and instr_cnt live in multicycle_ctrl.

## Test plan
- Reset mid-MEM of a STORE (MEM_LAT=2) -> MemWrite drops to 0 asynchronously, state IDLE, instr_cnt=0; no further strobes until start.
- start, then instr=0001_xxxxx (ADD) -> ir_load in cycle 1, ALUOp=000 + RegWrite + pc_en in cycle 3, instr_cnt=1.
- LOAD with MEM_LAT=2 -> MemtoReg high 3 cycles, RegWrite+pc_en only in the last; total 6 cycles.
- BRZ twice, zero=0 then zero=1 -> Branch 0 then 1 in EXEC, ALUOp=001, pc_en both times, instr_cnt +2.
- HALT -> done=1 from cycle 3 and held 10 cycles with no pc_en; start=1 -> FETCH next cycle, done=0.
- CNTW=4, 16 NOPs -> instr_cnt wraps 15 -> 0.
